// File: rtl/sample_capture.sv
// Decimating trigger/capture stage feeding the trace drawer. Captures DEPTH samples
// into a shadow buffer and publishes them to the display array on a vsync rising edge.
module sample_capture #(
  parameter int DEPTH   = 400,
  parameter int WIDTH   = 12,
  parameter int AUTO_TO = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_rise,
  input  logic [7:0]       decim,
  input  logic             vsync,
  output logic [WIDTH-1:0] data [DEPTH-1:0],
  output logic [1:0]       state,
  output logic             trig_seen,
  output logic [7:0]       frame_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

  typedef enum logic [1:0] {ARM = 2'd0, CAPTURE = 2'd1, HOLD = 2'd2} state_e;

  state_e           state_q;
  logic [7:0]       dec_cnt_q, dec_cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_ok_q;
  logic [AW-1:0]    auto_cnt_q;
  logic [IW-1:0]    wr_idx_q;
  logic             trig_flag_q;
  logic             trig_seen_q;
  logic [7:0]       frame_cnt_q;
  logic             vsync_q;
  logic [WIDTH-1:0] shadow_q [DEPTH-1:0];

  logic          strobe, trig_hit, auto_hit, vs_edge, sh_we;
  logic [IW-1:0] sh_addr;

  // >= rather than == so lowering decim mid-count cannot stall the strobe
  always_comb begin
    strobe    = adc_valid && (dec_cnt_q >= decim);
    dec_cnt_d = dec_cnt_q;
    if (adc_valid) dec_cnt_d = strobe ? 8'd0 : dec_cnt_q + 8'd1;
  end

  always_comb begin
    trig_hit = prev_ok_q && (trig_rise ? (prev_q < trig_level && adc_data >= trig_level)
                                       : (prev_q > trig_level && adc_data <= trig_level));
    auto_hit = (auto_cnt_q == AW'(AUTO_TO - 1));
    vs_edge  = vsync & ~vsync_q;
    sh_we    = 1'b0;
    sh_addr  = '0;
    if (state_q == ARM && strobe && (trig_hit || auto_hit)) sh_we = 1'b1;
    if (state_q == CAPTURE && strobe) begin
      sh_we   = 1'b1;
      sh_addr = wr_idx_q;
    end
  end

  // Shadow contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (sh_we) shadow_q[sh_addr] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARM;
      dec_cnt_q   <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      auto_cnt_q  <= '0;
      wr_idx_q    <= '0;
      trig_flag_q <= 1'b0;
      trig_seen_q <= 1'b0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      data        <= '{default: '0};
    end else begin
      vsync_q   <= vsync;
      dec_cnt_q <= dec_cnt_d;
      case (state_q)
        ARM: if (strobe) begin
          prev_q    <= adc_data;
          prev_ok_q <= 1'b1;
          if (trig_hit || auto_hit) begin
            wr_idx_q    <= IW'(1);
            trig_flag_q <= trig_hit;
            state_q     <= CAPTURE;
          end else begin
            auto_cnt_q <= auto_cnt_q + AW'(1);
          end
        end
        CAPTURE: if (strobe) begin
          wr_idx_q <= wr_idx_q + IW'(1);
          if (wr_idx_q == IW'(DEPTH - 1)) state_q <= HOLD;
        end
        HOLD: if (vs_edge) begin
          // Publish the whole trace at once so the drawer never sees a torn frame
          data        <= shadow_q;
          trig_seen_q <= trig_flag_q;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          prev_ok_q   <= 1'b0;
          auto_cnt_q  <= '0;
          state_q     <= ARM;
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign state     = state_q;
  assign trig_seen = trig_seen_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: full-size instance for trace content, plus a
// small-depth instance sharing the inputs for the frame counter wrap.
module tb_sample_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig_level;
  logic        trig_rise;
  logic [7:0]  decim;
  logic        vsync;

  logic [11:0] d_m [399:0];
  logic [1:0]  st_m;
  logic        ts_m;
  logic [7:0]  fc_m;
  logic [11:0] d_s [7:0];
  logic [1:0]  st_s;
  logic        ts_s;
  logic [7:0]  fc_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_capture u_dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_rise(trig_rise), .decim(decim), .vsync(vsync),
    .data(d_m), .state(st_m), .trig_seen(ts_m), .frame_cnt(fc_m)
  );

  sample_capture #(.DEPTH(8), .WIDTH(12), .AUTO_TO(16)) u_small (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_rise(trig_rise), .decim(decim), .vsync(vsync),
    .data(d_s), .state(st_s), .trig_seen(ts_s), .frame_cnt(fc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    adc_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_vsync();
    adc_valid = 1'b0;
    vsync     = 1'b1;
    tick();
    vsync     = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; trig_level = 12'd2048;
    trig_rise = 1'b1; decim = 8'd0; vsync = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", st_m, 0);
    chk("rst_data0", d_m[0], 0);
    chk("rst_data399", d_m[399], 0);
    chk("rst_frame", fc_m, 0);
    chk("rst_trig", ts_m, 0);

    // rising trigger on a ramp
    for (int v = 2000; v <= 2447; v++) send(12'(v));
    chk("rise_hold", st_m, 2);
    chk("rise_notear", d_m[0], 0);
    pulse_vsync();
    chk("rise_d0", d_m[0], 2048);
    chk("rise_d200", d_m[200], 2248);
    chk("rise_d399", d_m[399], 2447);
    chk("rise_trig", ts_m, 1);
    chk("rise_frame", fc_m, 1);
    chk("rise_arm", st_m, 0);

    // falling trigger, decim=3: kept samples 1097,1093,..,1001,997 -> trigger 997
    decim = 8'd3; trig_rise = 1'b0; trig_level = 12'd1000;
    for (int n = 0; n < 1700; n++) send(12'(1100 - n));
    chk("fall_hold", st_m, 2);
    for (int n = 1700; n < 1740; n++) send(12'(1100 - n));
    chk("hold_stream_state", st_m, 2);
    chk("hold_stream_data", d_m[0], 2048);
    adc_valid = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("fall_d0", d_m[0], 997);
    chk("fall_d1", d_m[1], 993);
    chk("fall_d249", d_m[249], 1);
    chk("fall_d250", d_m[250], 4093);
    chk("fall_d399", d_m[399], 3497);
    chk("fall_trig", ts_m, 1);
    chk("fall_frame", fc_m, 2);
    tick();

    // valid gaps with decim=1, vsync pulse mid-capture ignored
    decim = 8'd1; trig_rise = 1'b1; trig_level = 12'd1500;
    for (int v = 1; v <= 1298; v++) begin
      send(12'(1000 + v));
      if (v == 700) vsync = 1'b1;
      idle();
      vsync = 1'b0;
      if (v == 700) begin
        chk("cap_vs_state", st_m, 1);
        chk("cap_vs_data", d_m[0], 997);
      end
    end
    chk("gap_hold", st_m, 2);
    pulse_vsync();
    chk("gap_d0", d_m[0], 1500);
    chk("gap_d1", d_m[1], 1502);
    chk("gap_d399", d_m[399], 2298);
    chk("gap_frame", fc_m, 3);

    // auto trigger on a flat signal
    decim = 8'd0; trig_level = 12'd2048;
    for (int n = 0; n < 3999; n++) send(12'd500);
    chk("auto_arm", st_m, 0);
    send(12'd500);
    chk("auto_cap", st_m, 1);
    for (int n = 0; n < 399; n++) send(12'd500);
    chk("auto_hold", st_m, 2);
    pulse_vsync();
    chk("auto_d0", d_m[0], 500);
    chk("auto_d399", d_m[399], 500);
    chk("auto_trig", ts_m, 0);
    chk("auto_frame", fc_m, 4);

    // reset mid-capture at wr_idx=200
    for (int v = 2000; v <= 2247; v++) send(12'(v));
    chk("mid_cap", st_m, 1);
    adc_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", st_m, 0);
    chk("mid_rst_d0", d_m[0], 0);
    chk("mid_rst_d399", d_m[399], 0);
    chk("mid_rst_frame", fc_m, 0);

    // 256 publishes on the small instance
    for (int k = 0; k < 256; k++) begin
      send(12'd2047);
      send(12'd2048);
      for (int j = 0; j < 7; j++) send(12'(2049 + j));
      pulse_vsync();
      if (k == 0) begin
        chk("sm_d0", d_s[0], 2048);
        chk("sm_d7", d_s[7], 2055);
        chk("sm_trig", ts_s, 1);
        chk("sm_frame1", fc_s, 1);
      end
      if (k == 254) chk("sm_frame255", fc_s, 255);
    end
    chk("sm_wrap", fc_s, 0);
    chk("sm_arm", st_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
